// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, the write-port request
// record and a source/destination match helper used by hazard detection.
package cpu_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // x0 is hardwired to zero, so it never matches anything in flight.
  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] src,
                                    input logic [REG_ADDR_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction
endpackage

// File: rtl/lq_fifo.sv
// Load-destination FIFO. Pointers are one bit wider than the index so full and
// empty are distinguishable; every slot's valid bit and contents are exposed.
module lq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       push_data,
  input  logic               pop,
  output logic [W-1:0]       head,
  output logic               full,
  output logic               empty,
  output logic [DEPTH-1:0]   entry_valid,
  output logic [DEPTH*W-1:0] entry_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  count;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: a slot is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off                = AW'(i) - rd_ptr[AW-1:0];
    assign entry_valid[i]     = ({1'b0, off} < count);
    assign entry_data[i*W +: W] = mem[i];
  end
endmodule

// File: rtl/reg_wb_queue.sv
// Register-file write port: merges ALU results with in-order load responses,
// tracks outstanding load destinations and flags RAW hazards for decode.
module reg_wb_queue #(
  parameter int LQ_DEPTH = 4,
  parameter int XLEN     = cpu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_rd,
  output logic            ld_ready,
  input  logic            ld_resp_valid,
  input  logic [XLEN-1:0] ld_resp_data,
  output logic            ld_resp_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic            reg_w,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] wd
);
  import cpu_pkg::REG_ADDR_W;
  import cpu_pkg::wb_req_t;
  import cpu_pkg::rd_match;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // ld_issue/ld_ready pushes a load destination, ld_resp_valid/ld_resp_ready
  // pops one into the hold register. The ALU path has no backpressure.
  logic                           lq_full;
  logic                           lq_empty;
  logic [REG_ADDR_W-1:0]          lq_head;
  logic [LQ_DEPTH-1:0]            entry_valid;
  logic [LQ_DEPTH*REG_ADDR_W-1:0] entry_rd;
  logic                           resp_acc;
  logic                           alu_wr;
  logic                           hold_valid;
  logic [REG_ADDR_W-1:0]          hold_rd;
  logic [XLEN-1:0]                hold_data;
  wb_req_t                        wb_q;
  wb_req_t                        wb_next;

  assign ld_ready      = !lq_full;
  assign ld_resp_ready = !lq_empty && !hold_valid;
  assign resp_acc      = ld_resp_valid && ld_resp_ready;
  assign alu_wr        = alu_valid && (alu_rd != '0);

  lq_fifo #(.DEPTH(LQ_DEPTH), .W(REG_ADDR_W)) u_lq (
    .clk         (clk),
    .rst         (rst),
    .push        (ld_issue),
    .push_data   (ld_rd),
    .pop         (resp_acc),
    .head        (lq_head),
    .full        (lq_full),
    .empty       (lq_empty),
    .entry_valid (entry_valid),
    .entry_data  (entry_rd)
  );

  // Hold only refills from empty; a hold with rd==0 drains without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (resp_acc) begin
      hold_valid <= 1'b1;
      hold_rd    <= lq_head;
      hold_data  <= ld_resp_data;
    end else if (hold_valid && !alu_wr) begin
      hold_valid <= 1'b0;
    end
  end

  always_comb begin
    wb_next    = wb_q;
    wb_next.we = 1'b0;
    if (alu_wr) begin
      wb_next = '{we: 1'b1, rd: alu_rd, data: alu_data};
    end else if (hold_valid && (hold_rd != '0)) begin
      wb_next = '{we: 1'b1, rd: hold_rd, data: hold_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_next;
  end

  assign reg_w   = wb_q.we;
  assign rd_addr = wb_q.rd;
  assign wd      = wb_q.data;

  always_comb begin
    rs1_pending = hold_valid && rd_match(rs1_addr, hold_rd);
    rs2_pending = hold_valid && rd_match(rs2_addr, hold_rd);
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (entry_valid[i] && rd_match(rs1_addr, entry_rd[i*REG_ADDR_W +: REG_ADDR_W])) rs1_pending = 1'b1;
      if (entry_valid[i] && rd_match(rs2_addr, entry_rd[i*REG_ADDR_W +: REG_ADDR_W])) rs2_pending = 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed scenarios followed by random traffic, all
// checked each cycle against a queue-based reference of the write port.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic        ld_ready;
  logic        ld_resp_valid = 1'b0;
  logic [31:0] ld_resp_data = '0;
  logic        ld_resp_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        reg_w;
  logic [4:0]  rd_addr;
  logic [31:0] wd;

  int checks = 0;
  int errors = 0;

  // Reference state: outstanding load destinations, the single hold slot,
  // the write-port output and the expected sequence of register writes.
  int          lq_q[$];
  logic        m_hold_v;
  logic [4:0]  m_hold_rd;
  logic [31:0] m_hold_data;
  logic        m_reg_w;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [36:0] exp_q[$];

  reg_wb_queue #(.LQ_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .reg_w(reg_w), .rd_addr(rd_addr), .wd(wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (lq_q[i]) if (lq_q[i] == int'(r)) return 1'b1;
    return m_hold_v && (m_hold_rd == r);
  endfunction

  task automatic model_clear();
    lq_q.delete();
    exp_q.delete();
    m_hold_v = 1'b0; m_hold_rd = '0; m_hold_data = '0;
    m_reg_w = 1'b0;  m_rd = '0;      m_wd = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the
  // reference, then check the registered write port and the scoreboard.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic li, input logic [4:0] lrd,
                     input logic rv, input logic [31:0] rdat,
                     input logic [4:0] r1, input logic [4:0] r2);
    logic e_ldr, e_rr, acc, psh;
    logic [36:0] e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_issue = li; ld_rd = lrd; ld_resp_valid = rv; ld_resp_data = rdat;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    e_ldr = (lq_q.size() < DEPTH);
    e_rr  = (lq_q.size() > 0) && !m_hold_v;
    chk("ld_ready", ld_ready, e_ldr);
    chk("ld_resp_ready", ld_resp_ready, e_rr);
    chk("rs1_pending", rs1_pending, m_pend(r1));
    chk("rs2_pending", rs2_pending, m_pend(r2));
    acc = rv && e_rr;
    psh = li && e_ldr;
    if (av && ard != 5'd0) begin
      m_reg_w = 1'b1; m_rd = ard; m_wd = ad;
      exp_q.push_back({ard, ad});
    end else if (m_hold_v && m_hold_rd != 5'd0) begin
      m_reg_w = 1'b1; m_rd = m_hold_rd; m_wd = m_hold_data;
      exp_q.push_back({m_hold_rd, m_hold_data});
      m_hold_v = 1'b0;
    end else begin
      m_reg_w = 1'b0;
      m_hold_v = 1'b0;
    end
    if (acc) begin
      m_hold_v = 1'b1;
      m_hold_rd = 5'(lq_q.pop_front());
      m_hold_data = rdat;
    end
    if (psh) lq_q.push_back(int'(lrd));
    @(posedge clk);
    #1;
    chk("reg_w", reg_w, m_reg_w);
    chk("rd_addr", rd_addr, m_rd);
    chk("wd", wd, m_wd);
    if (reg_w === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_write", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("sb_write", {rd_addr, wd}, e);
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    cyc(0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    alu_valid = 0; ld_issue = 0; ld_resp_valid = 0;
    rs1_addr = r1; rs2_addr = r2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_ld_resp_ready", ld_resp_ready, 1'b0);
    chk("rst_reg_w", reg_w, 1'b0);
    chk("rst_rs1_pending", rs1_pending, 1'b0);
    chk("rst_rs2_pending", rs2_pending, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset(0, 0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    chk("rst_wd", wd, 32'd0);

    // T1: three loads queued, then reset mid-stream
    cyc(0, 0, 0, 1, 5'd1, 0, 0, 5'd1, 5'd2);
    cyc(0, 0, 0, 1, 5'd2, 0, 0, 5'd1, 5'd2);
    cyc(0, 0, 0, 1, 5'd3, 0, 0, 5'd3, 5'd2);
    do_reset(5'd1, 5'd3);

    // T2: single load, response one cycle later
    cyc(0, 0, 0, 1, 5'd5, 0, 0, 5'd5, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 5'd5, 0);
    idle(5'd5);
    chk("t2_reg_w", reg_w, 1'b1);
    chk("t2_rd_addr", rd_addr, 5'd5);
    chk("t2_wd", wd, 32'hDEADBEEF);
    idle(5'd5);

    // T3: ALU writes starve a filled hold for two cycles
    cyc(0, 0, 0, 1, 5'd7, 0, 0, 5'd7, 0);
    cyc(0, 0, 0, 1, 5'd8, 1, 32'h77, 5'd7, 5'd8);
    cyc(1, 5'd3, 32'h11, 0, 0, 1, 32'h88, 5'd7, 5'd3);
    chk("t3_alu1", {reg_w, rd_addr}, {1'b1, 5'd3});
    cyc(1, 5'd3, 32'h11, 0, 0, 1, 32'h88, 5'd7, 5'd3);
    chk("t3_alu2", {reg_w, rd_addr}, {1'b1, 5'd3});
    cyc(0, 0, 0, 0, 0, 1, 32'h88, 5'd7, 5'd8);
    chk("t3_hold", {reg_w, rd_addr, wd}, {1'b1, 5'd7, 32'h77});
    repeat (3) idle(5'd8);

    // T4: fill the queue, overflow attempt, push+pop, wrap-around drain
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 1, 5'(10 + i), 0, 0, 5'd10, 5'd14);
    chk("t4_full", ld_ready, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, 32'hA0, 5'd13, 0);
    cyc(0, 0, 0, 1, 5'd20, 0, 0, 5'd20, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hA1, 5'd11, 0);
    cyc(0, 0, 0, 1, 5'd21, 0, 0, 5'd21, 0);
    cyc(0, 0, 0, 1, 5'd22, 1, 32'hA2, 5'd22, 5'd12);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 1, 32'hB0 + i, 5'd21, 5'd22);

    // T5: a load to x0 is consumed but never written
    cyc(0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 5'd9);
    cyc(0, 0, 0, 1, 5'd9, 1, 32'hC0, 5'd0, 5'd9);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 32'hC9, 5'd0, 5'd9);

    // T6: WAW, ALU writes r4 while a load to r4 is in flight
    cyc(0, 0, 0, 1, 5'd4, 0, 0, 5'd4, 0);
    cyc(1, 5'd4, 32'h1, 0, 0, 0, 0, 5'd4, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h2, 5'd4, 0);
    chk("t6_pending_before", rs1_pending, 1'b1);
    idle(5'd4);
    chk("t6_load_write", {reg_w, rd_addr, wd}, {1'b1, 5'd4, 32'h2});
    idle(5'd4);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (n == 200) do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < 3 * DEPTH + 4; n++) cyc(0, 0, 0, 0, 0, 1, $urandom, 5'($urandom_range(0, 7)), 0);
    chk("drain_lq_empty", ld_resp_ready, 1'b0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
